// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: datapath widths, digest output FSM states and
// the initial hash values (IV) also used by the core's init logic.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [WORD_W-1:0] H0_INIT = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1_INIT = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2_INIT = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3_INIT = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4_INIT = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5_INIT = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6_INIT = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7_INIT = 32'h5be0cd19;

endpackage

// File: rtl/sha256_word_add32.sv
// 32-bit modulo-2^32 adder for one hash word. Kept as its own module so the
// add can be swapped for a carry-save / CPA implementation in one place.
// Ports:
//   a, b : addends
//   sum  : (a + b) mod 2^32, carry-out discarded
module sha256_word_add32
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);

    // Same-width add: the carry out of bit 31 is dropped by construction.
    assign sum = a + b;

endmodule

// File: rtl/sha256_digest_out.sv
// Output end of the SHA-256 working-register datapath. On start it captures
// Hi' = Hi + var_i (mod 2^32) for all eight words, then streams the 256-bit
// digest as eight 32-bit words (H0' first) over a valid/ready handshake.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset
//   start       : capture strobe (honoured only when idle)
//   work_i      : working vars a..h, a in [255:224]
//   hash_i      : previous hash H0..H7, H0 in [255:224]
//   dout_ready  : downstream accepts the current word
//   dout_valid  : dout_data is valid
//   dout_data   : current digest word
//   dout_last   : current word is word 7
//   digest_o    : registered full digest, same packing as hash_i
//   busy        : streaming in progress
//   done        : one-cycle pulse after the final word is accepted
module sha256_digest_out
    import sha256_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic [WORD_W*NUM_WORDS-1:0] work_i,
    input  logic [WORD_W*NUM_WORDS-1:0] hash_i,
    input  logic                        dout_ready,
    output logic                        dout_valid,
    output logic [WORD_W-1:0]           dout_data,
    output logic                        dout_last,
    output logic [WORD_W*NUM_WORDS-1:0] digest_o,
    output logic                        busy,
    output logic                        done
);

    state_t                      state_reg, state_next;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic [WORD_W*NUM_WORDS-1:0] digest_reg, digest_next;
    logic                        done_reg, done_next;

    logic [WORD_W*NUM_WORDS-1:0] sum_next;
    logic [WORD_W-1:0]           digest_words [NUM_WORDS];

    // Word gi sits at the gi-th slot from the top, so word 0 is [255:224].
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            sha256_word_add32 u_add (
                .a   (hash_i[(NUM_WORDS-1-gi)*WORD_W +: WORD_W]),
                .b   (work_i[(NUM_WORDS-1-gi)*WORD_W +: WORD_W]),
                .sum (sum_next[(NUM_WORDS-1-gi)*WORD_W +: WORD_W])
            );
            assign digest_words[gi] = digest_reg[(NUM_WORDS-1-gi)*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            digest_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            digest_reg <= digest_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        digest_next = digest_reg;
        done_next   = 1'b0;
        dout_valid  = 1'b0;
        busy        = 1'b0;
        dout_last   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    digest_next = sum_next;
                    idx_next    = '0;
                    state_next  = SEND;
                end
            end
            SEND: begin
                // start is deliberately ignored here, including on the edge
                // of the final transfer.
                dout_valid = 1'b1;
                busy       = 1'b1;
                dout_last  = (idx_reg == LAST_IDX);
                if (dout_ready) begin
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // After the last word the index wraps to 0, so in IDLE this shows word 0.
    assign dout_data = digest_words[idx_reg];
    assign digest_o  = digest_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_sha256_digest_out.sv
module tb_sha256_digest_out;
    import sha256_pkg::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [255:0] work_i = '0;
    logic [255:0] hash_i = '0;
    logic         dout_ready = 1'b0;
    logic         dout_valid;
    logic [31:0]  dout_data;
    logic         dout_last;
    logic [255:0] digest_o;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] exp_digest = '0;

    always #5 CLK = ~CLK;

    sha256_digest_out dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .work_i     (work_i),
        .hash_i     (hash_i),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_last  (dout_last),
        .digest_o   (digest_o),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: eight independent sums, each reduced mod 2^32 with plain arithmetic.
    function automatic logic [255:0] model_digest(input logic [255:0] h, input logic [255:0] w);
        logic [255:0] r;
        longint unsigned hw, ww;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            hw = longint'(h[255-32*i -: 32]);
            ww = longint'(w[255-32*i -: 32]);
            r[255-32*i -: 32] = 32'((hw + ww) % 64'h1_0000_0000);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        return exp_digest[255-32*k -: 32];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Issue start with the given operands; digest_o must switch exactly at that edge.
    task automatic capture(input string tag, input logic [255:0] h, input logic [255:0] w);
        hash_i = h;
        work_i = w;
        start  = 1'b1;
        check_eq({tag, "_digest_before"}, digest_o, exp_digest);
        @(posedge CLK); #1;
        start = 1'b0;
        exp_digest = model_digest(h, w);
        check_eq({tag, "_digest_after"}, digest_o, exp_digest);
        $display("capture %s: digest %h", tag, exp_digest);
    endtask

    // Stream the held digest. mode 0: ready=1, 1: 1,0,0 pattern, 2: random.
    // inj_k >= 0 asserts start with alt_work while word inj_k is current.
    task automatic stream(input string tag, input int mode, input int inj_k,
                          input logic [255:0] alt_work, input bit idle_after);
        int k;
        int cyc;
        bit r;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            check_eq({tag, "_valid"}, 256'(dout_valid), 256'(1));
            check_eq({tag, "_busy"},  256'(busy), 256'(1));
            check_eq({tag, "_data"},  256'(dout_data), 256'(exp_word(k)));
            check_eq({tag, "_last"},  256'(dout_last), 256'(k == 7));
            check_eq({tag, "_nodone"}, 256'(done), 256'(0));
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = $urandom_range(0, 1) == 1;
            endcase
            dout_ready = r;
            if (k == inj_k) begin
                start  = 1'b1;
                work_i = alt_work;
            end
            @(posedge CLK); #1;
            start = 1'b0;
            if (r) begin
                $display("xfer %s: word %0d = %h", tag, k, exp_word(k));
                k++;
            end
            cyc++;
        end
        if (k < 8) check_eq({tag, "_timeout"}, 256'(k), 256'(8));
        dout_ready = 1'b0;
        check_eq({tag, "_done"},      256'(done), 256'(1));
        check_eq({tag, "_busy_low"},  256'(busy), 256'(0));
        check_eq({tag, "_valid_low"}, 256'(dout_valid), 256'(0));
        check_eq({tag, "_digest_kept"}, digest_o, exp_digest);
        if (idle_after) begin
            @(posedge CLK); #1;
            check_eq({tag, "_done_pulse"}, 256'(done), 256'(0));
            check_eq({tag, "_still_idle"}, 256'(busy), 256'(0));
        end
    endtask

    logic [255:0] iv, h, w;

    initial begin
        iv = {H0_INIT, H1_INIT, H2_INIT, H3_INIT, H4_INIT, H5_INIT, H6_INIT, H7_INIT};

        // Reset state
        #1;
        check_eq("rst_valid",  256'(dout_valid), 256'(0));
        check_eq("rst_busy",   256'(busy), 256'(0));
        check_eq("rst_done",   256'(done), 256'(0));
        check_eq("rst_data",   256'(dout_data), 256'(0));
        check_eq("rst_digest", digest_o, 256'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Identity: IV + 0 streams the IV
        capture("ident", iv, 256'(0));
        stream("ident", 0, -1, 256'(0), 1'b1);

        // Wrap-around: FFFFFFFF + 1 in every word
        capture("wrap", {8{32'hffffffff}}, {8{32'h00000001}});
        stream("wrap", 0, -1, 256'(0), 1'b1);

        // No carry between words
        h = rand256(); w = rand256();
        h[255:192] = {32'h80000000, 32'h00000001};
        w[255:192] = {32'h80000000, 32'h00000000};
        capture("nocarry", h, w);
        check_eq("nocarry_w0", 256'(digest_o[255:224]), 256'(0));
        check_eq("nocarry_w1", 256'(digest_o[223:192]), 256'(1));
        stream("nocarry", 0, -1, 256'(0), 1'b1);

        // Backpressure 1,0,0 pattern
        capture("bp", rand256(), rand256());
        stream("bp", 1, -1, 256'(0), 1'b1);

        // start while busy during word 4
        capture("busystart", rand256(), rand256());
        stream("busystart", 0, 4, rand256(), 1'b1);

        // start coincident with the final transfer is ignored
        capture("laststart", rand256(), rand256());
        stream("laststart", 0, 7, rand256(), 1'b1);

        // Back-to-back: start in the done cycle
        capture("b2b_a", rand256(), rand256());
        stream("b2b_a", 0, -1, 256'(0), 1'b0);
        capture("b2b_b", rand256(), rand256());
        stream("b2b_b", 2, -1, 256'(0), 1'b1);

        // Random digests with random backpressure
        for (int t = 0; t < 6; t++) begin
            capture($sformatf("rnd%0d", t), rand256(), rand256());
            stream($sformatf("rnd%0d", t), 2, (t % 2 == 0) ? int'($urandom_range(0, 7)) : -1,
                   rand256(), 1'b1);
        end

        // Reset mid-stream after three words
        capture("midrst", rand256(), rand256());
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("midrst_data", 256'(dout_data), 256'(exp_word(i)));
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        #1;
        check_eq("midrst_valid",  256'(dout_valid), 256'(0));
        check_eq("midrst_busy",   256'(busy), 256'(0));
        check_eq("midrst_last",   256'(dout_last), 256'(0));
        check_eq("midrst_data0",  256'(dout_data), 256'(0));
        check_eq("midrst_digest", digest_o, 256'(0));
        check_eq("midrst_done",   256'(done), 256'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        dout_ready = 1'b0;
        exp_digest = '0;
        @(posedge CLK); #1;
        check_eq("postrst_busy",   256'(busy), 256'(0));
        check_eq("postrst_valid",  256'(dout_valid), 256'(0));
        check_eq("postrst_digest", digest_o, 256'(0));
        $display("reset mid-stream: outputs cleared");

        // Fresh stream after reset
        capture("postrst", rand256(), rand256());
        stream("postrst", 2, -1, 256'(0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
